// File: rtl/text_console.sv
// Character-stream front end for the 32x30 text-mode display: accepts bytes,
// tracks the cursor and drives write strobes into video memory port A.
module text_console #(
    parameter int          COLS  = 32,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic       vm_we,
    output logic [9:0] vm_addr,
    output logic [7:0] vm_data,
    output logic [4:0] cur_row,
    output logic [4:0] cur_col,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_SCREEN} state_t;

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [5:0] COL_END  = 6'(COLS);
    localparam logic [4:0] ROW_END  = 5'(ROWS);

    state_t     state, state_d;
    logic [4:0] row_d, col_d;
    logic [9:0] addr_d;
    logic [7:0] data_d;
    logic       we_d, ready_d, busy_d;
    logic [5:0] clr_col, clr_col_d;
    logic [4:0] clr_row, clr_row_d;
    logic       wrap_pend, wrap_pend_d;
    logic [4:0] next_row;

    assign next_row = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;

    // Every output is computed here as a next value and registered below, so
    // the first write of a sequence lands in the same cycle the state is entered.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state;
        row_d       = cur_row;
        col_d       = cur_col;
        addr_d      = vm_addr;
        data_d      = vm_data;
        we_d        = 1'b0;
        ready_d     = 1'b0;
        busy_d      = 1'b0;
        clr_col_d   = clr_col;
        clr_row_d   = clr_row;
        wrap_pend_d = wrap_pend;

        case (state)
            IDLE: begin
                ready_d = 1'b1;
                if (char_valid && char_ready) begin
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        state_d = WRITE;
                        ready_d = 1'b0;
                        we_d    = 1'b1;
                        addr_d  = {cur_row, cur_col};
                        data_d  = char_data;
                        if (cur_col == LAST_COL) begin
                            col_d       = 5'd0;
                            row_d       = next_row;
                            wrap_pend_d = 1'b1;
                        end else begin
                            col_d = cur_col + 5'd1;
                        end
                    end else begin
                        case (char_data)
                            8'h0A: begin
                                col_d     = 5'd0;
                                row_d     = next_row;
                                state_d   = CLR_LINE;
                                ready_d   = 1'b0;
                                busy_d    = 1'b1;
                                we_d      = 1'b1;
                                addr_d    = {next_row, 5'd0};
                                data_d    = BLANK;
                                clr_col_d = 6'd1;
                            end
                            8'h0D: col_d = 5'd0;
                            8'h08: begin
                                if (cur_col != 5'd0) begin
                                    col_d   = cur_col - 5'd1;
                                    state_d = WRITE;
                                    ready_d = 1'b0;
                                    we_d    = 1'b1;
                                    addr_d  = {cur_row, cur_col - 5'd1};
                                    data_d  = BLANK;
                                end
                            end
                            8'h0C: begin
                                row_d     = 5'd0;
                                col_d     = 5'd0;
                                state_d   = CLR_SCREEN;
                                ready_d   = 1'b0;
                                busy_d    = 1'b1;
                                we_d      = 1'b1;
                                addr_d    = 10'd0;
                                data_d    = BLANK;
                                clr_col_d = 6'd1;
                                clr_row_d = 5'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (wrap_pend) begin
                    // A line wrap blanks the newly entered row before more input.
                    wrap_pend_d = 1'b0;
                    state_d     = CLR_LINE;
                    busy_d      = 1'b1;
                    we_d        = 1'b1;
                    addr_d      = {cur_row, 5'd0};
                    data_d      = BLANK;
                    clr_col_d   = 6'd1;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            CLR_LINE: begin
                if (clr_col == COL_END) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    busy_d    = 1'b1;
                    we_d      = 1'b1;
                    addr_d    = {cur_row, clr_col[4:0]};
                    data_d    = BLANK;
                    clr_col_d = clr_col + 6'd1;
                end
            end
            CLR_SCREEN: begin
                if (clr_row == ROW_END) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    we_d   = 1'b1;
                    addr_d = {clr_row, clr_col[4:0]};
                    data_d = BLANK;
                    if (clr_col == COL_END - 6'd1) begin
                        clr_col_d = 6'd0;
                        clr_row_d = clr_row + 5'd1;
                    end else begin
                        clr_col_d = clr_col + 6'd1;
                    end
                end
            end
            default: state_d = CLR_SCREEN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_50mhz) begin
        if (!rst) begin
            state      <= CLR_SCREEN;
            cur_row    <= 5'd0;
            cur_col    <= 5'd0;
            vm_we      <= 1'b0;
            vm_addr    <= 10'd0;
            vm_data    <= BLANK;
            char_ready <= 1'b0;
            busy       <= 1'b1;
            clr_col    <= 6'd0;
            clr_row    <= 5'd0;
            wrap_pend  <= 1'b0;
        end else begin
            state      <= state_d;
            cur_row    <= row_d;
            cur_col    <= col_d;
            vm_we      <= we_d;
            vm_addr    <= addr_d;
            vm_data    <= data_d;
            char_ready <= ready_d;
            busy       <= busy_d;
            clr_col    <= clr_col_d;
            clr_row    <= clr_row_d;
            wrap_pend  <= wrap_pend_d;
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: expected VM writes are queued as stimulus is
// driven and a negedge monitor pops and compares each observed write.
module tb_text_console;

    logic       clk_50mhz = 1'b0;
    logic       rst = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready, vm_we, busy;
    logic [9:0] vm_addr;
    logic [7:0] vm_data;
    logic [4:0] cur_row, cur_col;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    logic [17:0] exp_q[$];

    text_console dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .char_valid(char_valid),
        .char_data (char_data),
        .char_ready(char_ready),
        .vm_we     (vm_we),
        .vm_addr   (vm_addr),
        .vm_data   (vm_data),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Write monitor: every observed strobe must match the head of the queue.
    always @(negedge clk_50mhz) begin
        if (vm_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(vm_we), 32'd0);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("write_addr", 32'(vm_addr), 32'(e[17:8]));
                check("write_data", 32'(vm_data), 32'(e[7:0]));
            end
        end
    end

    task automatic push_w(input logic [4:0] r, input logic [4:0] c, input logic [7:0] d);
        exp_q.push_back({r, c, d});
    endtask

    task automatic push_line(input int r);
        for (int k = 0; k < 32; k++) push_w(5'(r), 5'(k), 8'h20);
    endtask

    task automatic push_screen();
        for (int r = 0; r < 30; r++) push_line(r);
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (char_ready !== 1'b1 && n < budget) begin
            @(negedge clk_50mhz);
            n++;
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [7:0] b);
        int n;
        char_data  = b;
        char_valid = 1'b1;
        wait_ready(2000, n);
        @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        char_valid = 1'b0;
    endtask

    task automatic send_lat(input string tag, input logic [7:0] b, input int exp_lat);
        int n;
        send(b);
        wait_ready(2000, n);
        check(tag, 32'(n), 32'(exp_lat));
    endtask

    task automatic cursor(input string tag, input int r, input int c);
        check({tag, "_row"}, 32'(cur_row), 32'(r));
        check({tag, "_col"}, 32'(cur_col), 32'(c));
    endtask

    task automatic drained(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_50mhz);
        check("rst_we", 32'(vm_we), 32'd0);
        check("rst_addr", 32'(vm_addr), 32'd0);
        check("rst_data", 32'(vm_data), 32'h20);
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        cursor("rst_cursor", 0, 0);

        // Power-up full-screen clear
        push_screen();
        rst = 1'b1;
        @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        check("clr_busy", 32'(busy), 32'd1);
        wait_ready(2000, lat);
        check("post_reset_latency", 32'(lat), 32'd960);
        drained("post_reset_drained");
        check("post_reset_busy", 32'(busy), 32'd0);
        cursor("post_reset_cursor", 0, 0);

        // "AB"
        push_w(5'd0, 5'd0, 8'h41);
        send_lat("lat_A", 8'h41, 1);
        push_w(5'd0, 5'd1, 8'h42);
        send_lat("lat_B", 8'h42, 1);
        cursor("after_AB", 0, 2);
        send_lat("lat_cr0", 8'h0D, 0);
        cursor("after_cr0", 0, 0);

        // 32 printables: last one wraps and blanks row 1
        for (int i = 0; i < 32; i++) begin
            push_w(5'd0, 5'(i), 8'h78);
            if (i < 31) begin
                send_lat("lat_x", 8'h78, 1);
            end else begin
                push_line(1);
                send_lat("lat_x_wrap", 8'h78, 33);
            end
        end
        cursor("after_wrap", 1, 0);
        drained("wrap_drained");

        // Walk down to row 29 with LFs, then to column 5
        for (int i = 0; i < 28; i++) begin
            push_line(i + 2);
            send_lat("lat_lf", 8'h0A, 32);
        end
        cursor("at_row29", 29, 0);
        for (int i = 0; i < 5; i++) begin
            push_w(5'd29, 5'(i), 8'h71);
            send_lat("lat_q", 8'h71, 1);
        end
        cursor("at_29_5", 29, 5);

        // LF on the last row wraps to row 0 and blanks it
        push_line(0);
        send_lat("lat_lf_wrap", 8'h0A, 32);
        cursor("after_lf_wrap", 0, 0);
        drained("lf_wrap_drained");

        // CR at (0,7): no write
        for (int i = 0; i < 7; i++) begin
            push_w(5'd0, 5'(i), 8'h63);
            send_lat("lat_c", 8'h63, 1);
        end
        cursor("at_0_7", 0, 7);
        send_lat("lat_cr", 8'h0D, 0);
        cursor("after_cr", 0, 0);
        send_lat("lat_ignored", 8'h01, 0);
        cursor("after_ignored", 0, 0);
        drained("cr_drained");

        // Backspace at column 0 and in mid-line
        for (int i = 1; i <= 3; i++) begin
            push_line(i);
            send_lat("lat_lf_b", 8'h0A, 32);
        end
        send_lat("lat_bs_col0", 8'h08, 0);
        cursor("after_bs_col0", 3, 0);
        for (int i = 0; i < 4; i++) begin
            push_w(5'd3, 5'(i), 8'h64);
            send_lat("lat_d", 8'h64, 1);
        end
        push_w(5'd3, 5'd3, 8'h20);
        send_lat("lat_bs", 8'h08, 1);
        cursor("after_bs", 3, 3);
        check("bs_addr_held", 32'(vm_addr), 32'h063);
        drained("bs_drained");

        // FF with a reset pulse partway through; 'Z' held until the restart completes
        push_screen();
        char_data  = 8'h0C;
        char_valid = 1'b1;
        @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        char_data = 8'h5A;
        check("ff_busy", 32'(busy), 32'd1);
        check("ff_ready", 32'(char_ready), 32'd0);
        cursor("ff_cursor", 0, 0);
        repeat (98) @(negedge clk_50mhz);
        #1;
        check("ff_progress", 32'(exp_q.size()), 32'd861);
        rst = 1'b0;
        @(posedge clk_50mhz);
        #1;
        check("midrst_we", 32'(vm_we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        exp_q.delete();
        push_screen();
        push_w(5'd0, 5'd0, 8'h5A);
        @(negedge clk_50mhz);
        rst = 1'b1;
        @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        wait_ready(2000, lat);
        check("restart_latency", 32'(lat), 32'd960);
        @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        char_valid = 1'b0;
        cursor("after_Z", 0, 1);
        check("after_Z_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk_50mhz);
        drained("final_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
